imem_responder: RTL and testbench



---
 rtl/imem_pkg.sv | 14 +
 rtl/imem_intg_gen.sv | 20 ++
 rtl/imem_responder.sv | 108 ++++++++++
 tb/tb_imem_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared widths, limits and the response pipeline stage type for the fetch-side memory.
package imem_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned INTG_W      = 7;
  localparam int unsigned MAX_LATENCY = 4;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } resp_stage_t;

endpackage

// File: rtl/imem_intg_gen.sv
// Combinational 32->7 integrity: bit i is the inverted parity of data bits j with j mod 7 == i.
module imem_intg_gen
  import imem_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [INTG_W-1:0] intg_o
);

  for (genvar i = 0; i < int'(INTG_W); i++) begin : g_bit
    logic parity;
    always_comb begin
      parity = 1'b0;
      for (int j = i; j < int'(DATA_W); j += int'(INTG_W)) begin
        parity = parity ^ data_i[j];
      end
    end
    assign intg_o[i] = ~parity;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction fetch responder: preloadable word RAM answering req/gnt/rvalid with 0..4 cycles latency.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned LATENCY   = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              instr_req_i,
  input  logic [31:0]       instr_addr_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [31:0]       instr_rdata_o,
  output logic [INTG_W-1:0] instr_rdata_intg_o,
  output logic              instr_err_o,
  input  logic              stall_i,
  input  logic              load_we_i,
  input  logic [31:0]       load_addr_i,
  input  logic [31:0]       load_wdata_i
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [DATA_W-1:0] mem_q [MEM_WORDS];

  logic [31:0]       fetch_off;
  logic              fetch_err;
  logic [IDX_W-1:0]  fetch_idx;
  logic [DATA_W-1:0] fetch_word;
  logic [31:0]       load_off;
  logic              load_err;
  logic [IDX_W-1:0]  load_idx;

  resp_stage_t       accept_stage;
  resp_stage_t       rsp;
  logic [INTG_W-1:0] rsp_intg;

  assign instr_gnt_o = instr_req_i & ~stall_i & rst_ni;

  // Underflowed offsets are large, but the addr < BASE_ADDR term flags them regardless.
  always_comb begin
    fetch_off  = instr_addr_i - BASE_ADDR;
    fetch_err  = (fetch_off[1:0] != 2'b00) || (instr_addr_i < BASE_ADDR) ||
                 ((fetch_off >> 2) >= 32'(MEM_WORDS));
    fetch_idx  = fetch_off[IDX_W+1:2];
    fetch_word = fetch_err ? '0 : mem_q[fetch_idx];

    load_off   = load_addr_i - BASE_ADDR;
    load_err   = (load_off[1:0] != 2'b00) || (load_addr_i < BASE_ADDR) ||
                 ((load_off >> 2) >= 32'(MEM_WORDS));
    load_idx   = load_off[IDX_W+1:2];

    accept_stage = '0;
    if (instr_gnt_o) begin
      accept_stage.valid = 1'b1;
      accept_stage.rdata = fetch_word;
      accept_stage.err   = fetch_err;
    end
  end

  // RAM is not reset; a same-edge fetch samples the old word.
  always_ff @(posedge clk_i) begin
    if (load_we_i && !load_err) begin
      mem_q[load_idx] <= load_wdata_i;
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign rsp = accept_stage;
  end else begin : g_pipe
    resp_stage_t stage_q [LATENCY];
    resp_stage_t stage_d [LATENCY];

    always_comb begin
      stage_d[0] = accept_stage;
      for (int k = 1; k < int'(LATENCY); k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int k = 0; k < int'(LATENCY); k++) begin
          stage_q[k] <= '0;
        end
      end else begin
        for (int k = 0; k < int'(LATENCY); k++) begin
          stage_q[k] <= stage_d[k];
        end
      end
    end

    assign rsp = stage_q[LATENCY-1];
  end

  imem_intg_gen u_intg (
    .data_i (rsp.rdata),
    .intg_o (rsp_intg)
  );

  assign instr_rvalid_o     = rsp.valid;
  assign instr_rdata_o      = rsp.rdata;
  assign instr_err_o        = rsp.err;
  assign instr_rdata_intg_o = (rsp.valid && !rsp.err) ? rsp_intg : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: several imem_responder configurations share one stimulus stream.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, stall, we;
  logic [31:0] addr, la, wd;

  logic        g0, v0, e0, g1, v1, e1, g2, v2, e2, g3, v3, e3, gb, vb, eb;
  logic [31:0] d0, d1, d2, d3, db;
  logic [6:0]  i0, i1, i2, i3, ib;

  logic [31:0] gen_d;
  logic [6:0]  gen_q;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g0), .instr_rvalid_o(v0), .instr_rdata_o(d0), .instr_rdata_intg_o(i0),
    .instr_err_o(e0), .stall_i(stall), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
  imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g1), .instr_rvalid_o(v1), .instr_rdata_o(d1), .instr_rdata_intg_o(i1),
    .instr_err_o(e1), .stall_i(stall), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
  imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g2), .instr_rvalid_o(v2), .instr_rdata_o(d2), .instr_rdata_intg_o(i2),
    .instr_err_o(e2), .stall_i(stall), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
  imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .LATENCY(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(g3), .instr_rvalid_o(v3), .instr_rdata_o(d3), .instr_rdata_intg_o(i3),
    .instr_err_o(e3), .stall_i(stall), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));
  imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0000_1000), .LATENCY(0)) dutb (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gb), .instr_rvalid_o(vb), .instr_rdata_o(db), .instr_rdata_intg_o(ib),
    .instr_err_o(eb), .stall_i(stall), .load_we_i(we), .load_addr_i(la), .load_wdata_i(wd));

  imem_intg_gen u_gen (.data_i(gen_d), .intg_o(gen_q));

  function automatic logic [6:0] intg_model(input logic [31:0] d);
    logic [6:0] p;
    logic [2:0] k;
    p = '0;
    k = '0;
    for (int j = 0; j < 32; j++) begin
      p[k] = p[k] ^ d[j];
      k = (k == 3'd6) ? 3'd0 : k + 3'd1;
    end
    return ~p;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d,
                           input logic [6:0] i, input logic e,
                           input logic ev, input logic [31:0] ed, input logic ee);
    logic [6:0] ei;
    ei = (ev && !ee) ? intg_model(ed) : 7'd0;
    check_eq({tag, ".rvalid"}, 32'(v), 32'(ev));
    check_eq({tag, ".rdata"},  d, ed);
    check_eq({tag, ".intg"},   32'(i), 32'(ei));
    check_eq({tag, ".err"},    32'(e), 32'(ee));
  endtask

  // One cycle: drive at the falling edge, settle, leave the checks to the caller.
  task automatic cyc(input logic r, input logic [31:0] a, input logic s,
                     input logic w, input logic [31:0] lad, input logic [31:0] wdat);
    @(negedge clk);
    req = r; addr = a; stall = s; we = w; la = lad; wd = wdat;
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; stall = 1'b0; we = 1'b0;
    addr = '0; la = '0; wd = '0; gen_d = '0;

    // Reset: outputs 0 and no grant even with req high
    cyc(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("rst.gnt0", 32'(g0), 32'd0);
    check_rsp("rst.d0", v0, d0, i0, e0, 1'b0, 32'h0, 1'b0);
    check_rsp("rst.d2", v2, d2, i2, e2, 1'b0, 32'h0, 1'b0);
    idle(1);
    rst_n = 1'b1;

    // Integrity generator against the bench model
    gen_d = 32'hDEAD_BEEF; #1;
    check_eq("gen.deadbeef", 32'(gen_q), 32'(intg_model(32'hDEAD_BEEF)));
    gen_d = 32'h0; #1;
    check_eq("gen.zero", 32'(gen_q), 32'h7F);

    // Preload, including dropped misaligned and out-of-range writes
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0C, 32'hDEAD_BEEF);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h00, 32'hA0A0_0001);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h04, 32'hB0B0_0002);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h14, 32'h1111_1111);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h3C, 32'h0F0F_F0F0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h0E, 32'hFFFF_FFFF);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h0000_0BAD);
    idle(1);

    // Single-cycle read
    cyc(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("t1.gnt", 32'(g0), 32'd1);
    check_rsp("t1.d0", v0, d0, i0, e0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b0, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("t1.idle_gnt", 32'(g0), 32'd0);
    check_rsp("t1.idle", v0, d0, i0, e0, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Latency 2, back-to-back
    cyc(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t2.c0", v2, d2, i2, e2, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t2.c1", v2, d2, i2, e2, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t2.c2", v2, d2, i2, e2, 1'b1, 32'hA0A0_0001, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t2.c3", v2, d2, i2, e2, 1'b1, 32'hB0B0_0002, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t2.c4", v2, d2, i2, e2, 1'b0, 32'h0, 1'b0);
    idle(4);

    // Error responses and range boundaries
    cyc(1'b1, 32'h06, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t3.misal", v0, d0, i0, e0, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t3.past_end", v0, d0, i0, e0, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h0FFC, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t3.below_base", vb, db, ib, eb, 1'b1, 32'h0, 1'b1);
    check_rsp("t3.pipe_misal", v2, d2, i2, e2, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h3C, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t3.last_word", v0, d0, i0, e0, 1'b1, 32'h0F0F_F0F0, 1'b0);
    check_rsp("t3.pipe_end", v2, d2, i2, e2, 1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h1000, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("t3.base_ok", 32'(eb), 32'd0);
    idle(4);

    // Stall with latency 1
    cyc(1'b1, 32'h0C, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("t4.pre_gnt", 32'(g1), 32'd1);
    cyc(1'b1, 32'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    check_eq("t4.s1_gnt", 32'(g1), 32'd0);
    check_rsp("t4.s1", v1, d1, i1, e1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cyc(1'b1, 32'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    check_eq("t4.s2_gnt", 32'(g1), 32'd0);
    check_rsp("t4.s2", v1, d1, i1, e1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    check_eq("t4.s3_gnt", 32'(g1), 32'd0);
    check_rsp("t4.s3", v1, d1, i1, e1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_eq("t4.resume_gnt", 32'(g1), 32'd1);
    check_rsp("t4.resume", v1, d1, i1, e1, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t4.after", v1, d1, i1, e1, 1'b1, 32'hA0A0_0001, 1'b0);
    idle(4);

    // Write/read collision on word 5
    cyc(1'b1, 32'h14, 1'b0, 1'b1, 32'h14, 32'h2222_2222);
    check_rsp("t5.same_d0", v0, d0, i0, e0, 1'b1, 32'h1111_1111, 1'b0);
    cyc(1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t5.next_d0", v0, d0, i0, e0, 1'b1, 32'h2222_2222, 1'b0);
    check_rsp("t5.same_d1", v1, d1, i1, e1, 1'b1, 32'h1111_1111, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t5.next_d1", v1, d1, i1, e1, 1'b1, 32'h2222_2222, 1'b0);
    idle(4);

    // Reset mid-flight with latency 3
    cyc(1'b1, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 32'h08, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("t6.rst_gnt0", 32'(g0), 32'd0);
    check_rsp("t6.rst_d1", v1, d1, i1, e1, 1'b0, 32'h0, 1'b0);
    check_rsp("t6.rst_d3", v3, d3, i3, e3, 1'b0, 32'h0, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) begin
      check_eq("t6.no_rvalid", 32'(v3), 32'd0);
      cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    end
    cyc(1'b1, 32'h04, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t6.ram_kept", v0, d0, i0, e0, 1'b1, 32'hB0B0_0002, 1'b0);
    idle(2);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t6.d3_after", v3, d3, i3, e3, 1'b1, 32'hB0B0_0002, 1'b0);
    cyc(1'b0, 32'h00, 1'b0, 1'b0, 32'h0, 32'h0);
    check_rsp("t6.d3_quiet", v3, d3, i3, e3, 1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
